// File: rtl/pcs_wb_responder.sv
// pcs_wb_responder: memory-side responder for cache line writebacks.
// Latches one full line plus its line-aligned address, streams it out as
// BURST_WIDTH-bit beats under per-beat backpressure, then pulses mem_resp.
module pcs_wb_responder #(
  parameter int CACHE_LINE_SIZE = 256,
  parameter int BURST_WIDTH     = 64,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_write,
  input  logic [ADDR_WIDTH-1:0]      mem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  output logic                       mem_resp,
  output logic                       busy,
  output logic                       proto_err,
  output logic                       bmem_write,
  output logic [ADDR_WIDTH-1:0]      bmem_addr,
  output logic [BURST_WIDTH-1:0]     bmem_wdata,
  input  logic                       bmem_ready
);

  localparam int BEATS  = CACHE_LINE_SIZE / BURST_WIDTH;
  localparam int OFFSET = $clog2(CACHE_LINE_SIZE / 8);
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CACHE_LINE_SIZE-1:0] line_q, line_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       err_q, err_d;

  // Byte-offset bits of the request address never reach the bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr[OFFSET-1:0];

  // Slice the latched line into beats; beat 0 is the least-significant slice.
  logic [BURST_WIDTH-1:0] beat_w [BEATS];
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_w[gi] = line_q[gi*BURST_WIDTH +: BURST_WIDTH];
    end
  endgenerate

  // State, beat counter, line/address registers and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, stream beats in BURST, pulse in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    addr_d  = addr_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (mem_write) begin
          line_d  = mem_wdata;
          addr_d  = {mem_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (bmem_ready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A request arriving while a line is still in flight is dropped and flagged.
    if (mem_write && (state_q != IDLE)) begin
      err_d = 1'b1;
    end
  end

  // Every output comes straight from registers; nothing from mem_* reaches them.
  assign mem_resp   = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign proto_err  = err_q;
  assign bmem_write = (state_q == BURST);
  assign bmem_addr  = addr_q;
  assign bmem_wdata = beat_w[cnt_q];

endmodule

// File: tb/tb_pcs_wb_responder.sv
// tb_pcs_wb_responder: scoreboard bench for pcs_wb_responder.
// The driver keeps a transaction-level reference model (work remaining in the
// current writeback) and pushes expected beats/responses into queues; the
// monitor pops and compares whenever the DUT shows a beat or a response.
module tb_pcs_wb_responder;

  localparam int LINE  = 256;
  localparam int BW    = 64;
  localparam int AW    = 32;
  localparam int BEATS = LINE / BW;
  localparam int OFF   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_write = 1'b0;
  logic [AW-1:0]   mem_addr = '0;
  logic [LINE-1:0] mem_wdata = '0;
  logic            mem_resp;
  logic            busy;
  logic            proto_err;
  logic            bmem_write;
  logic [AW-1:0]   bmem_addr;
  logic [BW-1:0]   bmem_wdata;
  logic            bmem_ready = 1'b0;

  pcs_wb_responder #(
    .CACHE_LINE_SIZE(LINE),
    .BURST_WIDTH    (BW),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_resp  (mem_resp),
    .busy      (busy),
    .proto_err (proto_err),
    .bmem_write(bmem_write),
    .bmem_addr (bmem_addr),
    .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } beat_t;

  beat_t beat_q[$];
  int    resp_q[$];

  int checks = 0;
  int errors = 0;
  int line_id = 0;

  // Reference model: beats still owed, response pending this cycle, sticky error.
  int            m_rem = 0;
  bit            m_resp = 1'b0;
  bit            m_err = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] pending_addr = '0;
  bit            wr_prev = 1'b0;
  bit            rdy_prev = 1'b0;

  // Expected per-cycle outputs, published by the driver for the monitor.
  bit            exp_busy = 1'b0;
  bit            exp_bw = 1'b0;
  bit            exp_resp = 1'b0;
  bit            exp_err = 1'b0;
  logic [AW-1:0] exp_addr = '0;

  task automatic chk(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of stimulus: advance the model over the previous cycle, then drive.
  task automatic step(input bit wr, input logic [AW-1:0] a, input logic [LINE-1:0] d, input bit rdy);
    bit    was_idle;
    beat_t b;
    @(posedge clk);
    #1;
    was_idle = (m_rem == 0) && !m_resp;
    if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_rem > 0) begin
      if (rdy_prev) begin
        m_rem--;
        if (m_rem == 0) m_resp = 1'b1;
      end
    end else if (wr_prev) begin
      m_rem  = BEATS;
      m_addr = pending_addr;
    end
    if (wr_prev && !was_idle) m_err = 1'b1;

    exp_busy = (m_rem > 0) || m_resp;
    exp_bw   = (m_rem > 0);
    exp_resp = m_resp;
    exp_err  = m_err;
    exp_addr = m_addr;

    mem_write  = wr;
    mem_addr   = a;
    mem_wdata  = d;
    bmem_ready = rdy;

    if (wr && !exp_busy) begin
      pending_addr = a & ~((AW'(1) << OFF) - AW'(1));
      for (int i = 0; i < BEATS; i++) begin
        b.a = pending_addr;
        b.d = d[i*BW +: BW];
        beat_q.push_back(b);
      end
      line_id++;
      resp_q.push_back(line_id);
    end
    wr_prev  = wr;
    rdy_prev = rdy;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, '0, 1'b1);
  endtask

  // Asynchronous reset in the middle of a cycle with arbitrary inputs applied.
  task automatic do_reset();
    #2;
    mem_write  = 1'($urandom);
    mem_addr   = $urandom;
    mem_wdata  = {8{$urandom}};
    bmem_ready = 1'($urandom);
    rst_n      = 1'b0;
    #1;
    chk("rst_mem_resp",   mem_resp,   0);
    chk("rst_busy",       busy,       0);
    chk("rst_proto_err",  proto_err,  0);
    chk("rst_bmem_write", bmem_write, 0);
    chk("rst_bmem_addr",  bmem_addr,  0);
    chk("rst_bmem_wdata", bmem_wdata, 0);
    beat_q.delete();
    resp_q.delete();
    m_rem = 0; m_resp = 1'b0; m_err = 1'b0; m_addr = '0;
    wr_prev = 1'b0; rdy_prev = 1'b0;
    exp_busy = 1'b0; exp_bw = 1'b0; exp_resp = 1'b0; exp_err = 1'b0; exp_addr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    rst_n     = 1'b1;
  endtask

  // Monitor: compare control outputs every cycle, pop beats and responses as they appear.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy",       busy,       exp_busy);
      chk("bmem_write", bmem_write, exp_bw);
      chk("mem_resp",   mem_resp,   exp_resp);
      chk("proto_err",  proto_err,  exp_err);
      chk("bmem_addr",  bmem_addr,  exp_addr);
      if (bmem_write) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          chk("beat_data", bmem_wdata, beat_q[0].d);
          chk("beat_addr", bmem_addr,  beat_q[0].a);
          if (bmem_ready) begin
            $display("beat addr=%h data=%h", bmem_addr, bmem_wdata);
            void'(beat_q.pop_front());
          end
        end
      end
      if (mem_resp) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          $display("resp line=%0d", resp_q[0]);
          chk("resp_beats_left", beat_q.size(), 0);
          void'(resp_q.pop_front());
        end
      end
    end
  end

  logic [LINE-1:0] line_a;
  logic [LINE-1:0] line_b;
  logic [LINE-1:0] rnd_line;
  logic [AW-1:0]   rnd_addr;

  initial begin
    line_a = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    line_b = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};

    // Power-on reset.
    #12;
    chk("por_busy",       busy,       0);
    chk("por_bmem_write", bmem_write, 0);
    chk("por_bmem_wdata", bmem_wdata, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single writeback with ready held high.
    step(1'b1, 32'h1234_567F, line_a, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    #2;
    chk("t1_addr_literal",  bmem_addr,  32'h1234_5660);
    chk("t1_beat0_literal", bmem_wdata, {16{4'hA}});
    idle_steps(6);

    // Back-to-back: second request exactly when the responder is idle again.
    step(1'b1, 32'h0000_1000, line_a, 1'b1);
    idle_steps(5);
    step(1'b1, 32'h0000_2020, line_b, 1'b1);
    idle_steps(7);

    // Backpressure: ready low for two cycles on beats 1 and 3.
    step(1'b1, 32'h1234_567F, line_a, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    idle_steps(4);

    // Protocol violation: a second request two cycles into the burst is dropped.
    step(1'b1, 32'hABCD_0040, line_a, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 32'h5555_0080, line_b, 1'b1);
    idle_steps(6);
    chk("err_sticky", proto_err, 1);

    // Reset during beat 2, then a clean request.
    step(1'b1, 32'h0F0F_0F00, line_b, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    do_reset();
    step(1'b1, 32'h7777_7767, line_a, 1'b1);
    idle_steps(7);

    // Randomized traffic with random backpressure and occasional collisions.
    for (int c = 0; c < 600; c++) begin
      for (int w = 0; w < LINE / 32; w++) rnd_line[w*32 +: 32] = $urandom;
      rnd_addr = $urandom;
      step($urandom_range(0, 5) == 0, rnd_addr, rnd_line, $urandom_range(0, 3) != 0);
      if (c == 300) do_reset();
    end
    idle_steps(BEATS * 4 + 4);

    chk("drain_beats", beat_q.size(), 0);
    chk("drain_resps", resp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
